mu0_control: RTL

MU0_CONTROL -- requirements
Module: mu0_control

---
 rtl/mu0_control.sv | 118 +++++++++++
 1 files changed

// File: rtl/mu0_control.sv
// mu0_control: three-state MU0 sequencer (FETCH / EXECUTE / HALT) with a Ready memory handshake.
// Revision 1.0
`default_nettype none

module mu0_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Ready,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic [1:0] M,
  output logic       Rd,
  output logic       Wr,
  output logic       Fetch,
  output logic       Halted
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  localparam logic [1:0] M_Y    = 2'b00;
  localparam logic [1:0] M_ADD  = 2'b01;
  localparam logic [1:0] M_INC  = 2'b10;
  localparam logic [1:0] M_SUB  = 2'b11;

  state_t state_q;
  state_t state_d;
  state_t w_state;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (Ready) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (F <= 4'd3) begin
          if (Ready) state_d = ST_FETCH;
        end else if (F == 4'd7) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // While reset is held the outputs look like FETCH, with every enable and strobe masked off.
  assign w_state = Reset ? state_q : ST_FETCH;

  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    M        = M_Y;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Fetch    = (w_state == ST_FETCH);
    Halted   = (w_state == ST_HALT);
    case (w_state)
      ST_FETCH: begin
        X_sel = 1'b1;
        M     = M_INC;
        Rd    = Reset;
        IR_En = Ready & Reset;
        PC_En = Ready & Reset;
      end
      ST_EXECUTE: begin
        case (F)
          4'd0: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            Acc_En   = Ready;
          end
          4'd1: begin
            Addr_sel = 1'b1;
            Wr       = 1'b1;
          end
          4'd2, 4'd3: begin
            Addr_sel = 1'b1;
            Rd       = 1'b1;
            M        = (F == 4'd2) ? M_ADD : M_SUB;
            Acc_En   = Ready;
          end
          4'd4, 4'd5, 4'd6: begin
            Y_sel = 1'b1;
            PC_En = (F == 4'd4) | ((F == 4'd5) & ~N) | ((F == 4'd6) & ~Z);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
